pll_lock_sequencer: RTL
=======================

# pll_lock_sequencer

Sequences the two cascaded ECP5 PLLs (25→200 MHz, 200→60/30 MHz) at power-up and after lock loss. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to be stable for a programmable interval. Only then does it release a reset to the 30 MHz LED-matrix logic. It runs on the 25 MHz board clock, never on a PLL output, so it keeps working while the PLLs are unlocked.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of the PLL reset pulse, in `clk_pin` cycles (≥1).
- `LOCK_TIMEOUT`, 65535: maximum number of cycles spent in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 1024: number of consecutive locked cycles required before release (≥1).
- `MAX_RETRIES`, 3: number of timeouts allowed before FAULT (≥0).
- `CNT_W`, 8: width of the lock-loss counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_pin`  in  1  25 MHz board clock. All logic runs in this domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `pll_locked`  in  1  LOCKED output of the second PLL. Asynchronous to `clk_pin`.
- `retry_req`  in  1  single-cycle pulse. Exits FAULT; ignored in all other states.
- `pll_rst`  out  1  active-high reset to both PLLs.
- `sys_rst_n`  out  1  active-low reset for downstream logic. High only in RUN.
- `fault`  out  1  high while in FAULT.
- `state_o`  out  3  current state encoding, for debug/LED.
- `lock_loss_cnt`  out  CNT_W  number of RUN→lock-lost events. Saturating.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to produce `locked_s`. Only `locked_s` is used.
- States (`state_o` encoding): RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET_PLL: `pll_rst`=1. A counter runs from 0 to RST_CYCLES-1, then the FSM goes to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`=1, go to STABLE with the stable counter at 0.
  - Otherwise the timeout counter increments. When it reaches LOCK_TIMEOUT-1:
    - if retries < MAX_RETRIES, increment retries and go to RESET_PLL;
    - otherwise go to FAULT.
- STABLE:
  - If `locked_s`=0, go to WAIT_LOCK. The timeout counter is cleared; retries are unchanged.
  - If `locked_s`=1 and the counter = STABLE_CYCLES-1, go to RUN and clear retries.
  - Otherwise increment the counter.
- RUN: `sys_rst_n`=1. If `locked_s`=0, increment `lock_loss_cnt` (saturating at 2^CNT_W-1) and go to RESET_PLL.
- FAULT: `pll_rst`=1, `sys_rst_n`=0, `fault`=1. On `retry_req`, clear retries and go to RESET_PLL.
- All counters are sized by $clog2 of their limit. Comparisons are exact (==), with no wrap. Retries are checked before incrementing.

## Timing
- Reset values: state=RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `fault`=0, `state_o`=0, `lock_loss_cnt`=0; all internal counters are 0.
- All outputs are registered. `pll_rst`, `sys_rst_n` and `fault` are decoded from registered state, with no combinational path from inputs.
- Lock acquisition: `pll_locked` rising at cycle t gives `locked_s` high at t+2. STABLE is entered at t+3, and `sys_rst_n` rises at t+3+STABLE_CYCLES.
- Lock loss in RUN: `sys_rst_n` falls 3 cycles after `pll_locked` falls (2 sync + 1 state). `pll_rst` rises in the same cycle.
- Glitch shorter than 1 cycle: it may be missed by the synchronizer. This is accepted.
- Simultaneous timeout and `locked_s`=1 in WAIT_LOCK: lock wins, and the FSM goes to STABLE.
- When `rst_n` is asserted mid-sequence, all outputs return to their reset values asynchronously. `lock_loss_cnt` is cleared.
- RESET_PLL lasts exactly RST_CYCLES cycles. A full WAIT_LOCK timeout lasts exactly LOCK_TIMEOUT cycles.

## Structure
- Package `pll_seq_pkg` holds the state enum with its fixed encodings above, and the `state_o` width constant.
- Sub-module `sync_2ff` (parameterless, 1 bit, async active-low reset to 0) forms the `pll_locked` synchronizer. It is reused for other async status inputs.
- The FSM and counters live in one module with a single always block per register group.

## Test plan
(Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.)
- Release reset; `pll_locked` rises 10 cycles after `pll_rst` falls -> `pll_rst` high for exactly 4 cycles; `sys_rst_n` rises 11 cycles after `pll_locked`; `state_o`=3.
- `pll_locked` held 0 -> three `pll_rst` pulses of 4 cycles, spaced 100 cycles apart in WAIT_LOCK; then `fault`=1, `state_o`=4, `pll_rst`=1. Pulse `retry_req` -> RESET_PLL, and retries restart at 0.
- In STABLE, drop `pll_locked` for 3 cycles at stable count 5 -> back to WAIT_LOCK with no `pll_rst` pulse; `sys_rst_n` rises only after 8 fresh consecutive locked cycles.
- In RUN, drop `pll_locked` -> `sys_rst_n`=0 and `pll_rst`=1 exactly 3 cycles later; `lock_loss_cnt` goes 0→1. Repeat 260 times with CNT_W=8 -> `lock_loss_cnt` saturates at 255.
- Assert `rst_n` mid-STABLE and mid-RUN -> outputs reach their reset values with no clock edge; after release, the sequence restarts from RESET_PLL.
- Lock arriving in the same cycle the timeout counter reaches 99 -> transition to STABLE, with no retry and no `pll_rst` pulse.

Source files
------------

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types for the PLL lock sequencer: state encoding
//               (also exported on state_o) and its width.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    localparam int c_state_w = 3;

    // Encodings are visible on state_o, so they are fixed
    typedef enum logic [c_state_w-1:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } pll_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous status bit.
//               Clears to 0 on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;

    // First stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            o_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Power-up / lock-loss sequencer for the cascaded board PLLs.
//               Pulses the PLL reset, waits for lock with timeout and bounded
//               retries, demands a stable lock interval, then releases the
//               downstream reset. Runs on the board clock only.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                 clk_pin,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 retry_req,
    output logic                 pll_rst,
    output logic                 sys_rst_n,
    output logic                 fault,
    output logic [c_state_w-1:0] state_o,
    output logic [CNT_W-1:0]     lock_loss_cnt
);

    // Counter widths; a limit of 1 still needs a 1-bit register
    localparam int c_rst_w = (RST_CYCLES > 1)    ? $clog2(RST_CYCLES)    : 1;
    localparam int c_to_w  = $clog2(LOCK_TIMEOUT);
    localparam int c_stb_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int c_rty_w = (MAX_RETRIES > 0)   ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_stb_w-1:0] c_stb_last = c_stb_w'(STABLE_CYCLES - 1);
    localparam logic [c_rty_w-1:0] c_max_rty  = c_rty_w'(MAX_RETRIES);

    pll_state_e         r_state;
    pll_state_e         w_state_next;
    logic               w_locked_s;
    logic [c_rst_w-1:0] r_rst_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [c_stb_w-1:0] r_stb_cnt;
    logic [c_rty_w-1:0] r_retries;

    logic w_rst_done;
    logic w_timeout;
    logic w_stable_done;
    logic w_retry_ok;

    sync_2ff u_sync_locked (
        .clk     (clk_pin),
        .rst_n   (rst_n),
        .i_async (pll_locked),
        .o_sync  (w_locked_s)
    );

    assign w_rst_done    = (r_rst_cnt == c_rst_last);
    assign w_timeout     = (r_to_cnt  == c_to_last);
    assign w_stable_done = (r_stb_cnt == c_stb_last);
    assign w_retry_ok    = (r_retries <  c_max_rty);

    // Next-state decision; lock takes priority over a coincident timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET_PLL: if (w_rst_done) w_state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_locked_s)     w_state_next = S_STABLE;
                else if (w_timeout) w_state_next = w_retry_ok ? S_RESET_PLL : S_FAULT;
            end
            S_STABLE: begin
                if (!w_locked_s)        w_state_next = S_WAIT_LOCK;
                else if (w_stable_done) w_state_next = S_RUN;
            end
            S_RUN:       if (!w_locked_s) w_state_next = S_RESET_PLL;
            S_FAULT:     if (retry_req)   w_state_next = S_RESET_PLL;
            default:                      w_state_next = S_RESET_PLL;
        endcase
    end

    // State register plus outputs decoded from the next state, so every output is a flop
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RESET_PLL;
            state_o   <= S_RESET_PLL;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fault     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            state_o   <= w_state_next;
            pll_rst   <= (w_state_next == S_RESET_PLL) || (w_state_next == S_FAULT);
            sys_rst_n <= (w_state_next == S_RUN);
            fault     <= (w_state_next == S_FAULT);
        end
    end

    // Reset-pulse width counter: runs only while staying in RESET_PLL, zero on entry
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n)
            r_rst_cnt <= '0;
        else if (r_state == S_RESET_PLL && w_state_next == S_RESET_PLL)
            r_rst_cnt <= r_rst_cnt + c_rst_w'(1);
        else
            r_rst_cnt <= '0;
    end

    // Lock timeout counter: runs only while staying in WAIT_LOCK, zero on entry
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_state == S_WAIT_LOCK && w_state_next == S_WAIT_LOCK)
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        else
            r_to_cnt <= '0;
    end

    // Stable-lock counter: runs only while staying in STABLE, zero on entry
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n)
            r_stb_cnt <= '0;
        else if (r_state == S_STABLE && w_state_next == S_STABLE)
            r_stb_cnt <= r_stb_cnt + c_stb_w'(1);
        else
            r_stb_cnt <= '0;
    end

    // Retry counter: bumps on a timeout retry, clears on reaching RUN or leaving FAULT
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n)
            r_retries <= '0;
        else if (r_state == S_WAIT_LOCK && w_state_next == S_RESET_PLL)
            r_retries <= r_retries + c_rty_w'(1);
        else if ((r_state == S_STABLE && w_state_next == S_RUN) ||
                 (r_state == S_FAULT  && w_state_next == S_RESET_PLL))
            r_retries <= '0;
    end

    // Saturating count of lock losses seen while running
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n)
            lock_loss_cnt <= '0;
        else if (r_state == S_RUN && w_state_next == S_RESET_PLL && lock_loss_cnt != '1)
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
    end

endmodule
`default_nettype wire
